// File: rtl/alu_if.sv
// alu_if: operand-in / result-out valid-ready bundle for alu_seq
interface alu_if #(parameter int DATA_WIDTH = 32);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            alu_inst;
    logic [DATA_WIDTH-1:0] data_rs1;
    logic [DATA_WIDTH-1:0] source_2;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] ALU_result;
    logic                  zero;
    modport master(output in_valid, alu_inst, data_rs1, source_2, out_ready,
                   input in_ready, out_valid, ALU_result, zero);
    modport slave(input in_valid, alu_inst, data_rs1, source_2, out_ready,
                  output in_ready, out_valid, ALU_result, zero);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered handshaked ALU with optional iterative shift-add multiplier
module alu_seq #(
    parameter int DATA_WIDTH = 32,
    parameter bit MUL_EN     = 1'b1
) (
    input logic clk,
    input logic rst,
    alu_if.slave bus
);
    localparam int SW = $clog2(DATA_WIDTH);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    state_t                state;
    logic [DATA_WIDTH-1:0] a, b, alu_res, res, mcand, mplier, acc, acc_nxt;
    logic [SW-1:0]         sh, cnt;
    logic                  zero_r, accept, is_mul;
    assign a              = bus.data_rs1;
    assign b              = bus.source_2;
    assign sh             = b[SW-1:0];
    assign bus.in_ready   = (state == IDLE) || (state == DONE && bus.out_ready);
    assign accept         = bus.in_valid && bus.in_ready;
    assign is_mul         = MUL_EN && bus.alu_inst == 4'b1010;
    assign acc_nxt        = acc + (mplier[0] ? mcand : '0);
    assign bus.out_valid  = state == DONE;
    assign bus.ALU_result = res;
    assign bus.zero       = zero_r;
    // single-cycle operations; unlisted opcodes (and mul when the multiplier is absent) add
    always_comb begin
        alu_res = a + b;
        case (bus.alu_inst)
            4'b0110: alu_res = a - b;
            4'b0000: alu_res = a & b;
            4'b0001: alu_res = a | b;
            4'b0011: alu_res = a ^ b;
            4'b0100: alu_res = a << sh;
            4'b0101: alu_res = a >> sh;
            4'b0111: alu_res = DATA_WIDTH'($signed(a) >>> sh);
            4'b1000: alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            4'b1001: alu_res = {{(DATA_WIDTH-1){1'b0}}, a < b};
            default: alu_res = a + b;
        endcase
    end
    // control FSM with result/zero registers and the shift-add multiply datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            res    <= '0;
            zero_r <= 1'b1;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == MUL) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + SW'(1);
            if (cnt == SW'(DATA_WIDTH - 1)) begin
                res    <= acc_nxt;
                zero_r <= acc_nxt == '0;
                state  <= DONE;
            end
        end else if (accept) begin
            if (is_mul) begin
                mcand  <= a;
                mplier <= b;
                acc    <= '0;
                cnt    <= '0;
                state  <= MUL;
            end else begin
                res    <= alu_res;
                zero_r <= alu_res == '0;
                state  <= DONE;
            end
        end else if (state == DONE && bus.out_ready) begin
            state <= IDLE;
        end
    end
endmodule
